axi4_burst_mem_slave: RTL and testbench

AXI4_BURST_MEM_SLAVE -- requirements
Module: axi4_burst_mem_slave
Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits (legal: 32, 64).
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, byte-address width.
REQ-003 SHALL have parameter MEMORY_DEPTH, default 1024, number of DATA_WIDTH words.
REQ-004 SHALL have port ACLK  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port ARESETn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port AWADDR  in  ADDR_WIDTH  write burst start byte address.
REQ-007 SHALL have port AWLEN  in  8  write beats minus one.
REQ-008 SHALL have port AWSIZE  in  3  log2 bytes per beat.
REQ-009 SHALL have port AWBURST  in  2  burst type: 00 FIXED, 01 INCR, 10 WRAP.
REQ-010 SHALL have port AWVALID  in  1  write address valid.
REQ-011 SHALL have port AWREADY  out  1  write address ready.
REQ-012 SHALL have port WDATA  in  DATA_WIDTH  write data.
REQ-013 SHALL have port WSTRB  in  DATA_WIDTH/8  byte-lane enables.
REQ-014 SHALL have port WLAST  in  1  master's last-beat marker.
REQ-015 SHALL have port WVALID  in  1  write data valid.
REQ-016 SHALL have port WREADY  out  1  write data ready.
REQ-017 SHALL have port BRESP  out  2  write response: 00 OKAY, 10 SLVERR.
REQ-018 SHALL have port BVALID  out  1  write response valid.
REQ-019 SHALL have port BREADY  in  1  write response ready.
REQ-020 SHALL have port ARADDR  in  ADDR_WIDTH  read burst start byte address.
REQ-021 SHALL have port ARLEN  in  8  read beats minus one.
REQ-022 SHALL have port ARSIZE  in  3  log2 bytes per beat.
REQ-023 SHALL have port ARBURST  in  2  read burst type, encoded as AWBURST.
REQ-024 SHALL have port ARVALID  in  1  read address valid.
REQ-025 SHALL have port ARREADY  out  1  read address ready.
REQ-026 SHALL have port RDATA  out  DATA_WIDTH  read data.
REQ-027 SHALL have port RRESP  out  2  read response: 00 OKAY, 10 SLVERR.
REQ-028 SHALL have port RLAST  out  1  last read beat.
REQ-029 SHALL have port RVALID  out  1  read data valid.
REQ-030 SHALL have port RREADY  in  1  read data ready.
Function
REQ-031 SHALL run independent write (W_IDLE, W_DATA, W_RESP) and read (R_IDLE, R_DATA) FSMs; AWREADY=1 only in W_IDLE, ARREADY=1 only in R_IDLE.
REQ-032 SHALL, on AW handshake: latch word address = AWADDR >> log2(DATA_WIDTH/8), AWLEN, AWBURST and error flag; go to W_DATA; WREADY=1 from next cycle, held high throughout W_DATA.
REQ-033 SHALL flag a burst in error (reads and writes alike) when any of these holds: size != log2(DATA_WIDTH/8); burst type 11; WRAP with len not in {1,3,7,15}; INCR with start word + len + 1 > MEMORY_DEPTH; FIXED/WRAP with start word >= MEMORY_DEPTH.
REQ-034 SHALL, on each W beat (WVALID && WREADY) of a non-error burst, write only the byte lanes whose WSTRB bit is 1; an error burst writes nothing.
REQ-035 SHALL advance the beat address: FIXED unchanged; INCR +1; WRAP +1, wrapping within the aligned (len+1)-word window (address bits below log2(len+1) wrap, upper bits fixed).
REQ-036 SHALL count beats with an 8-bit counter and end the burst on beat len regardless of WLAST; WLAST low on beat len, or high earlier, SHALL set BRESP=10 without aborting the beat count.
REQ-037 SHALL assert BVALID in the cycle after the final W beat; BRESP = 10 if the burst is in error, else 00; hold both until BREADY, then return to W_IDLE (one idle cycle minimum between bursts).
REQ-038 SHALL, on AR handshake, latch address/len/burst/error and assert RVALID in the next cycle; RDATA = mem[beat address] (or 0 if in error), RRESP = 10 if in error else 00, RLAST=1 on beat len; all held stable while RVALID && !RREADY.
REQ-039 SHALL, on each R handshake, advance the address per REQ-035; after the RLAST beat, drop RVALID/RLAST and return to R_IDLE; error bursts still deliver exactly len+1 beats.
REQ-040 SHALL return the pre-write value when a read beat and a write beat target the same word in the same cycle; the write takes effect on the following cycle.
REQ-041 SHALL accept AW and AR in the same cycle; channels never stall each other.
Reset
REQ-042 SHALL, while ARESETn=0 (asynchronously): both FSMs idle, AWREADY/ARREADY=0, WREADY/BVALID/RVALID/RLAST=0, BRESP/RRESP=00, RDATA=0; AWREADY/ARREADY=1 from the first rising edge after release.
REQ-043 SHALL abandon an in-flight burst on reset without issuing any response; memory contents SHALL NOT be cleared, and words already written persist.
Verification
REQ-044 INCR: AWADDR=0x10, AWLEN=3, data 0xA0..0xA3, WSTRB=F -> words 4..7 = A0..A3, BRESP=00; AR same -> 4 beats matching, RLAST on beat 4 only.
REQ-045 WRAP: AWADDR=0x18 (word 6), AWLEN=3 -> beats write words 6, 7, 4, 5; ARBURST=WRAP read returns the same order.
REQ-046 Strobe: word 0 = 0xFFFFFFFF, write 0x12345678 with WSTRB=0101 -> word 0 = 0xFF34FF78.
REQ-047 Out of bound: AWADDR=(MEMORY_DEPTH-2)*4, AWLEN=3 -> no memory change, BRESP=10; same AR -> 4 beats, RRESP=10, RDATA=0.
REQ-048 Back-pressure/reset: hold RREADY=0 for 5 cycles -> RDATA, RLAST stable; deassert ARESETn mid write burst -> BVALID never rises, next AW accepted.

---
 rtl/axi4_burst_mem_slave_if.sv | 58 +++++
 rtl/axi4_burst_mem_slave.sv | 263 ++++++++++++++++++++++++++
 tb/tb_axi4_burst_mem_slave.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_burst_mem_slave_if.sv
// AXI4 burst memory bus: AW/W/B/AR/R channel bundle.
// Master drives requests and data; slave drives readies and responses.
interface axi4_burst_mem_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [7:0]              AWLEN;
  logic [2:0]              AWSIZE;
  logic [1:0]              AWBURST;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WLAST;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [7:0]              ARLEN;
  logic [2:0]              ARSIZE;
  logic [1:0]              ARBURST;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RLAST;
  logic                    RVALID;
  logic                    RREADY;

  modport slave (
    input  AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BRESP, BVALID,
    input  BREADY,
    input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );

  modport master (
    output AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BRESP, BVALID,
    output BREADY,
    output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );
endinterface

// File: rtl/axi4_burst_mem_slave.sv
// AXI4 burst memory slave: FIXED/INCR/WRAP bursts, byte strobes,
// independent write and read FSMs, SLVERR on illegal or out-of-range bursts.
module axi4_burst_mem_slave #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int MEMORY_DEPTH = 1024
) (
  input logic                  ACLK,
  input logic                  ARESETn,
  axi4_burst_mem_slave_if.slave s
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int SH = $clog2(NB);
  localparam int IW = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam int EW = ADDR_WIDTH + 9;

  localparam logic [2:0]    SIZE_OK = 3'(SH);
  localparam logic [EW-1:0] DEPTH_E = EW'(MEMORY_DEPTH);

  localparam logic [1:0] B_FIXED  = 2'b00;
  localparam logic [1:0] B_INCR   = 2'b01;
  localparam logic [1:0] B_WRAP   = 2'b10;
  localparam logic [1:0] RESP_OK  = 2'b00;
  localparam logic [1:0] RESP_ERR = 2'b10;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  typedef logic [ADDR_WIDTH-1:0] waddr_t;

  function automatic logic burst_err(
    input waddr_t     wa,
    input logic [7:0] len,
    input logic [2:0] size,
    input logic [1:0] burst
  );
    logic [EW-1:0] start_w;
    logic [EW-1:0] end_w;
    logic          e;
    start_w = EW'(wa);
    end_w   = start_w + EW'(len) + EW'(1);
    e       = (size != SIZE_OK);
    case (burst)
      B_FIXED: e = e | (start_w >= DEPTH_E);
      B_INCR:  e = e | (end_w > DEPTH_E);
      B_WRAP:  e = e | (start_w >= DEPTH_E) |
                   !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  // WRAP keeps the bits above log2(len+1) and wraps the ones below.
  function automatic waddr_t next_addr(
    input waddr_t     wa,
    input logic [7:0] len,
    input logic [1:0] burst
  );
    waddr_t inc;
    waddr_t mask;
    waddr_t res;
    inc  = wa + waddr_t'(1);
    mask = waddr_t'(len);
    case (burst)
      B_INCR:  res = inc;
      B_WRAP:  res = (wa & ~mask) | (inc & mask);
      default: res = wa;
    endcase
    return res;
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [MEMORY_DEPTH];

  logic        live_q;
  logic [1:0]  w_state_q, w_state_d;
  waddr_t      w_addr_q, w_addr_d;
  logic [7:0]  w_len_q, w_len_d;
  logic [7:0]  w_cnt_q, w_cnt_d;
  logic [1:0]  w_burst_q, w_burst_d;
  logic        w_err_q, w_err_d;
  logic        w_bad_q, w_bad_d;
  logic [1:0]  bresp_q, bresp_d;

  logic [0:0]            r_state_q, r_state_d;
  waddr_t                r_addr_q, r_addr_d;
  logic [7:0]            r_len_q, r_len_d;
  logic [7:0]            r_cnt_q, r_cnt_d;
  logic [1:0]            r_burst_q, r_burst_d;
  logic                  r_err_q, r_err_d;
  logic                  rlast_q, rlast_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic   aw_hs, w_hs, w_last, ar_hs;
  waddr_t aw_word, ar_word;

  assign aw_word = waddr_t'(s.AWADDR >> SH);
  assign ar_word = waddr_t'(s.ARADDR >> SH);

  assign s.AWREADY = live_q && (w_state_q == W_IDLE);
  assign s.WREADY  = (w_state_q == W_DATA);
  assign s.BVALID  = (w_state_q == W_RESP);
  assign s.BRESP   = bresp_q;
  assign s.ARREADY = live_q && (r_state_q == R_IDLE);
  assign s.RVALID  = (r_state_q == R_DATA);
  assign s.RLAST   = rlast_q;
  assign s.RRESP   = rresp_q;
  assign s.RDATA   = rdata_q;

  assign aw_hs  = s.AWVALID && s.AWREADY;
  assign w_hs   = s.WVALID && s.WREADY;
  assign ar_hs  = s.ARVALID && s.ARREADY;
  assign w_last = (w_cnt_q == w_len_q);

  // Write FSM: latch burst, count beats to len, then hold the response.
  always_comb begin
    w_state_d = w_state_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_burst_d = w_burst_q;
    w_err_d   = w_err_q;
    w_bad_d   = w_bad_q;
    bresp_d   = bresp_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          w_addr_d  = aw_word;
          w_len_d   = s.AWLEN;
          w_burst_d = s.AWBURST;
          w_err_d   = burst_err(aw_word, s.AWLEN,
                                s.AWSIZE, s.AWBURST);
          w_cnt_d   = 8'd0;
          w_bad_d   = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          w_bad_d = w_bad_q | (w_last != s.WLAST);
          if (w_last) begin
            w_state_d = W_RESP;
            bresp_d   = (w_err_q | w_bad_d) ? RESP_ERR : RESP_OK;
          end else begin
            w_addr_d = next_addr(w_addr_q, w_len_q, w_burst_q);
            w_cnt_d  = w_cnt_q + 8'd1;
          end
        end
      end
      W_RESP: begin
        if (s.BREADY) begin
          w_state_d = W_IDLE;
          bresp_d   = RESP_OK;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read FSM: data is fetched into a register when a beat is
  // presented, so it stays stable under back-pressure and sees
  // the pre-write value of a word written in the same cycle.
  always_comb begin
    r_state_d = r_state_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_burst_d = r_burst_q;
    r_err_d   = r_err_q;
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_addr_d  = ar_word;
          r_len_d   = s.ARLEN;
          r_burst_d = s.ARBURST;
          r_err_d   = burst_err(ar_word, s.ARLEN,
                                s.ARSIZE, s.ARBURST);
          r_cnt_d   = 8'd0;
          r_state_d = R_DATA;
          rlast_d   = (s.ARLEN == 8'd0);
          rresp_d   = r_err_d ? RESP_ERR : RESP_OK;
          rdata_d   = r_err_d ? '0 : mem_q[IW'(ar_word)];
        end
      end
      R_DATA: begin
        if (s.RREADY) begin
          if (rlast_q) begin
            r_state_d = R_IDLE;
            rlast_d   = 1'b0;
            rresp_d   = RESP_OK;
            rdata_d   = '0;
          end else begin
            r_addr_d = next_addr(r_addr_q, r_len_q, r_burst_q);
            r_cnt_d  = r_cnt_q + 8'd1;
            rlast_d  = (r_cnt_d == r_len_q);
            rdata_d  = r_err_q ? '0 : mem_q[IW'(r_addr_d)];
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Channel state; reset abandons any burst without a response.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      live_q    <= 1'b0;
      w_state_q <= W_IDLE;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_burst_q <= '0;
      w_err_q   <= 1'b0;
      w_bad_q   <= 1'b0;
      bresp_q   <= RESP_OK;
      r_state_q <= R_IDLE;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_burst_q <= '0;
      r_err_q   <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OK;
      rdata_q   <= '0;
    end else begin
      live_q    <= 1'b1;
      w_state_q <= w_state_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_burst_q <= w_burst_d;
      w_err_q   <= w_err_d;
      w_bad_q   <= w_bad_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_burst_q <= r_burst_d;
      r_err_q   <= r_err_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  // Byte-lane write of accepted beats; contents survive reset.
  always_ff @(posedge ACLK) begin
    if (w_hs && !w_err_q) begin
      for (int b = 0; b < NB; b++) begin
        if (s.WSTRB[b]) begin
          mem_q[IW'(w_addr_q)][8*b +: 8] <= s.WDATA[8*b +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_axi4_burst_mem_slave.sv
// Directed bench for axi4_burst_mem_slave: vector table of
// write/read bursts plus hand sequences for multi-cycle corners.
module tb_axi4_burst_mem_slave;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int DEPTH = 1024;
  localparam int NV = 17;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  axi4_burst_mem_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  axi4_burst_mem_slave #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEMORY_DEPTH(DEPTH)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .s(bus)
  );

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    bit               do_w;
    logic [15:0]      waddr;
    logic [7:0]       wlen;
    logic [2:0]       wsize;
    logic [1:0]       wburst;
    logic [31:0]      base;
    logic [3:0]       strb;
    logic [1:0]       bresp;
    logic [15:0]      raddr;
    logic [7:0]       rlen;
    logic [2:0]       rsize;
    logic [1:0]       rburst;
    logic [1:0]       rresp;
    logic [3:0][31:0] rd;
  } vec_t;

  vec_t tv [NV];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input bit dw, input logic [15:0] wa, input logic [7:0] wl,
    input logic [2:0] ws, input logic [1:0] wb,
    input logic [31:0] base, input logic [3:0] strb,
    input logic [1:0] br, input logic [15:0] ra,
    input logic [7:0] rl, input logic [2:0] rs,
    input logic [1:0] rb, input logic [1:0] rr,
    input logic [31:0] d0, input logic [31:0] d1,
    input logic [31:0] d2, input logic [31:0] d3);
    vec_t v;
    v.do_w = dw; v.waddr = wa; v.wlen = wl; v.wsize = ws;
    v.wburst = wb; v.base = base; v.strb = strb; v.bresp = br;
    v.raddr = ra; v.rlen = rl; v.rsize = rs; v.rburst = rb;
    v.rresp = rr; v.rd = {d3, d2, d1, d0};
    return v;
  endfunction

  task automatic do_write(
    input logic [15:0] a, input logic [7:0] len,
    input logic [2:0] sz, input logic [1:0] bt,
    input logic [31:0] base, input logic [3:0] strb,
    input int wl_mode, output logic [1:0] resp, output int lat);
    int t;
    lat = -1;
    resp = 2'bxx;
    @(negedge ACLK);
    bus.AWADDR = a; bus.AWLEN = len; bus.AWSIZE = sz;
    bus.AWBURST = bt; bus.AWVALID = 1'b1;
    t = 0;
    while (!bus.AWREADY && t < 50) begin @(negedge ACLK); t++; end
    @(posedge ACLK); #1 bus.AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      @(negedge ACLK);
      bus.WDATA = base + 32'(i);
      bus.WSTRB = strb;
      bus.WLAST = (wl_mode == 1) ? 1'b0 :
                  (wl_mode == 2) ? 1'b1 : (i == int'(len));
      bus.WVALID = 1'b1;
      t = 0;
      while (!bus.WREADY && t < 50) begin @(negedge ACLK); t++; end
      @(posedge ACLK); #1;
      bus.WVALID = 1'b0;
      bus.WLAST = 1'b0;
    end
    @(negedge ACLK);
    t = 0;
    while (!bus.BVALID && t < 50) begin @(negedge ACLK); t++; end
    if (bus.BVALID) begin
      lat = t;
      resp = bus.BRESP;
    end
    bus.BREADY = 1'b1;
    @(posedge ACLK); #1 bus.BREADY = 1'b0;
  endtask

  task automatic do_read(
    input logic [15:0] a, input logic [7:0] len,
    input logic [2:0] sz, input logic [1:0] bt,
    input logic [1:0] er, input logic [3:0][31:0] ed,
    input int stall, input string tag);
    int t;
    logic [31:0] held;
    logic held_last;
    @(negedge ACLK);
    bus.ARADDR = a; bus.ARLEN = len; bus.ARSIZE = sz;
    bus.ARBURST = bt; bus.ARVALID = 1'b1;
    t = 0;
    while (!bus.ARREADY && t < 50) begin @(negedge ACLK); t++; end
    @(posedge ACLK); #1 bus.ARVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      @(negedge ACLK);
      t = 0;
      while (!bus.RVALID && t < 50) begin @(negedge ACLK); t++; end
      chk($sformatf("%s b%0d rvalid", tag, i), 64'(bus.RVALID), 64'd1);
      chk($sformatf("%s b%0d rdata", tag, i), 64'(bus.RDATA),
          64'(ed[i]));
      chk($sformatf("%s b%0d rresp", tag, i), 64'(bus.RRESP), 64'(er));
      chk($sformatf("%s b%0d rlast", tag, i), 64'(bus.RLAST),
          64'(i == int'(len)));
      held = bus.RDATA;
      held_last = bus.RLAST;
      if (stall > 0 && (i == 0 || i == int'(len))) begin
        repeat (stall) begin
          @(negedge ACLK);
          chk($sformatf("%s b%0d stable", tag, i),
              {31'd0, bus.RVALID, bus.RLAST, bus.RDATA},
              {31'd0, 1'b1, held_last, held});
        end
      end
      bus.RREADY = 1'b1;
      @(posedge ACLK); #1 bus.RREADY = 1'b0;
    end
    @(negedge ACLK);
    chk({tag, " end"}, 64'({bus.RVALID, bus.RLAST}), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] br;
    int lat;
    bit seen;

    bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0;
    bus.AWBURST = '0; bus.AWVALID = 1'b0;
    bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0;
    bus.WVALID = 1'b0; bus.BREADY = 1'b0;
    bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0;
    bus.ARBURST = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;

    tv[0]  = mk(1, 16'h0010, 3, 2, 2'b01, 32'hA0, 4'hF, 2'b00,
                16'h0010, 3, 2, 2'b01, 2'b00,
                32'hA0, 32'hA1, 32'hA2, 32'hA3);
    tv[1]  = mk(1, 16'h0018, 3, 2, 2'b10, 32'hB0, 4'hF, 2'b00,
                16'h0018, 3, 2, 2'b10, 2'b00,
                32'hB0, 32'hB1, 32'hB2, 32'hB3);
    tv[2]  = mk(0, 16'h0000, 0, 2, 2'b01, 32'h0, 4'hF, 2'b00,
                16'h0010, 3, 2, 2'b01, 2'b00,
                32'hB2, 32'hB3, 32'hB0, 32'hB1);
    tv[3]  = mk(1, 16'h0000, 0, 2, 2'b01, 32'hFFFFFFFF, 4'hF, 2'b00,
                16'h0000, 0, 2, 2'b01, 2'b00,
                32'hFFFFFFFF, 0, 0, 0);
    tv[4]  = mk(1, 16'h0000, 0, 2, 2'b01, 32'h12345678, 4'h5, 2'b00,
                16'h0000, 0, 2, 2'b01, 2'b00,
                32'hFF34FF78, 0, 0, 0);
    tv[5]  = mk(1, 16'h0FF8, 1, 2, 2'b01, 32'hC0, 4'hF, 2'b00,
                16'h0FF8, 1, 2, 2'b01, 2'b00,
                32'hC0, 32'hC1, 0, 0);
    tv[6]  = mk(1, 16'h0FF8, 3, 2, 2'b01, 32'hD0, 4'hF, 2'b10,
                16'h0FF8, 3, 2, 2'b01, 2'b10,
                0, 0, 0, 0);
    tv[7]  = mk(0, 16'h0000, 0, 2, 2'b01, 32'h0, 4'hF, 2'b00,
                16'h0FF8, 1, 2, 2'b01, 2'b00,
                32'hC0, 32'hC1, 0, 0);
    tv[8]  = mk(1, 16'h0040, 2, 2, 2'b00, 32'hE0, 4'hF, 2'b00,
                16'h0040, 1, 2, 2'b00, 2'b00,
                32'hE2, 32'hE2, 0, 0);
    tv[9]  = mk(1, 16'h0010, 0, 1, 2'b01, 32'h99, 4'hF, 2'b10,
                16'h0010, 3, 2, 2'b01, 2'b00,
                32'hB2, 32'hB3, 32'hB0, 32'hB1);
    tv[10] = mk(1, 16'h0010, 2, 2, 2'b10, 32'h77, 4'hF, 2'b10,
                16'h0010, 0, 1, 2'b01, 2'b10,
                0, 0, 0, 0);
    tv[11] = mk(1, 16'h0000, 0, 2, 2'b11, 32'h55, 4'hF, 2'b10,
                16'h0000, 0, 2, 2'b11, 2'b10,
                0, 0, 0, 0);
    tv[12] = mk(0, 16'h0000, 0, 2, 2'b01, 32'h0, 4'hF, 2'b00,
                16'h0000, 0, 2, 2'b01, 2'b00,
                32'hFF34FF78, 0, 0, 0);
    tv[13] = mk(1, 16'h0020, 0, 2, 2'b01, 32'h11, 4'hF, 2'b00,
                16'h0020, 0, 2, 2'b01, 2'b00,
                32'h11, 0, 0, 0);
    tv[14] = mk(1, 16'h1000, 0, 2, 2'b00, 32'h33, 4'hF, 2'b10,
                16'h1000, 0, 2, 2'b00, 2'b10,
                0, 0, 0, 0);
    tv[15] = mk(1, 16'h002C, 1, 2, 2'b10, 32'hF0, 4'hF, 2'b00,
                16'h0028, 1, 2, 2'b01, 2'b00,
                32'hF1, 32'hF0, 0, 0);
    tv[16] = mk(1, 16'h0FFC, 0, 2, 2'b01, 32'h44, 4'hF, 2'b00,
                16'h0FFC, 0, 2, 2'b01, 2'b00,
                32'h44, 0, 0, 0);

    // Reset state
    @(negedge ACLK);
    chk("rst ready", 64'({bus.AWREADY, bus.ARREADY, bus.WREADY}), 64'd0);
    chk("rst valid", 64'({bus.BVALID, bus.RVALID, bus.RLAST}), 64'd0);
    chk("rst resp", 64'({bus.BRESP, bus.RRESP}), 64'd0);
    chk("rst rdata", 64'(bus.RDATA), 64'd0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("post-rst ready", 64'({bus.AWREADY, bus.ARREADY}), 64'b11);

    for (int k = 0; k < NV; k++) begin
      if (tv[k].do_w) begin
        do_write(tv[k].waddr, tv[k].wlen, tv[k].wsize, tv[k].wburst,
                 tv[k].base, tv[k].strb, 0, br, lat);
        chk($sformatf("v%0d bresp", k), 64'(br), 64'(tv[k].bresp));
        chk($sformatf("v%0d blat", k), 64'(lat), 64'd0);
      end
      do_read(tv[k].raddr, tv[k].rlen, tv[k].rsize, tv[k].rburst,
              tv[k].rresp, tv[k].rd, 0, $sformatf("v%0d", k));
    end

    // WLAST high early: error response, data still written
    do_write(16'h0030, 1, 2, 2'b01, 32'h60, 4'hF, 2, br, lat);
    chk("wlast early bresp", 64'(br), 64'h2);
    do_read(16'h0030, 1, 2, 2'b01, 2'b00,
            {32'h0, 32'h0, 32'h61, 32'h60}, 0, "wlast early");
    // WLAST missing on final beat
    do_write(16'h0038, 0, 2, 2'b01, 32'h70, 4'hF, 1, br, lat);
    chk("wlast missing bresp", 64'(br), 64'h2);
    chk("wlast missing blat", 64'(lat), 64'd0);

    // Back-pressure on first and last read beats
    do_read(16'h0010, 3, 2, 2'b01, 2'b00,
            {32'hB1, 32'hB0, 32'hB3, 32'hB2}, 5, "bp");

    // AW and AR together; read of word 8 racing its write
    @(negedge ACLK);
    bus.AWADDR = 16'h0020; bus.AWLEN = 0; bus.AWSIZE = 2;
    bus.AWBURST = 2'b01; bus.AWVALID = 1'b1;
    bus.ARADDR = 16'h0020; bus.ARLEN = 0; bus.ARSIZE = 2;
    bus.ARBURST = 2'b01; bus.ARVALID = 1'b1;
    chk("dual ready", 64'({bus.AWREADY, bus.ARREADY}), 64'b11);
    @(posedge ACLK); #1;
    bus.AWVALID = 1'b0;
    bus.ARVALID = 1'b0;
    @(negedge ACLK);
    bus.WDATA = 32'h22; bus.WSTRB = 4'hF; bus.WLAST = 1'b1;
    bus.WVALID = 1'b1; bus.RREADY = 1'b1;
    chk("dual wr/rd ready", 64'({bus.WREADY, bus.RVALID}), 64'b11);
    chk("dual pre-write rdata", 64'(bus.RDATA), 64'h11);
    @(posedge ACLK); #1;
    bus.WVALID = 1'b0; bus.WLAST = 1'b0; bus.RREADY = 1'b0;
    @(negedge ACLK);
    chk("dual bvalid", 64'({bus.BVALID, bus.BRESP}), 64'b100);
    bus.BREADY = 1'b1;
    @(posedge ACLK); #1 bus.BREADY = 1'b0;
    do_read(16'h0020, 0, 2, 2'b01, 2'b00,
            {32'h0, 32'h0, 32'h0, 32'h22}, 0, "dual after");

    // Reset in the middle of a write burst
    @(negedge ACLK);
    bus.AWADDR = 16'h0080; bus.AWLEN = 3; bus.AWSIZE = 2;
    bus.AWBURST = 2'b01; bus.AWVALID = 1'b1;
    @(posedge ACLK); #1 bus.AWVALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge ACLK);
      chk($sformatf("midrst wready%0d", i), 64'(bus.WREADY), 64'd1);
      bus.WDATA = 32'hF0 + 32'(i); bus.WSTRB = 4'hF;
      bus.WLAST = 1'b0; bus.WVALID = 1'b1;
      @(posedge ACLK); #1 bus.WVALID = 1'b0;
    end
    @(negedge ACLK);
    ARESETn = 1'b0;
    #1;
    chk("midrst outs",
        64'({bus.AWREADY, bus.WREADY, bus.BVALID, bus.ARREADY}),
        64'd0);
    seen = 1'b0;
    repeat (2) begin @(negedge ACLK); seen |= bus.BVALID; end
    ARESETn = 1'b1;
    repeat (6) begin @(negedge ACLK); seen |= bus.BVALID; end
    chk("midrst no bvalid", 64'(seen), 64'd0);
    chk("midrst awready", 64'(bus.AWREADY), 64'd1);
    do_write(16'h0090, 0, 2, 2'b01, 32'h5A, 4'hF, 0, br, lat);
    chk("after rst bresp", 64'(br), 64'd0);
    chk("after rst blat", 64'(lat), 64'd0);
    do_read(16'h0080, 1, 2, 2'b01, 2'b00,
            {32'h0, 32'h0, 32'hF1, 32'hF0}, 0, "persist beats");
    do_read(16'h0000, 0, 2, 2'b01, 2'b00,
            {32'h0, 32'h0, 32'h0, 32'hFF34FF78}, 0, "persist w0");
    do_read(16'h0090, 0, 2, 2'b01, 2'b00,
            {32'h0, 32'h0, 32'h0, 32'h5A}, 0, "after rst data");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
